// File: rtl/uart_crc_frame_rx.sv
// uart_crc_frame_rx: 8N1 UART receiver grouping bytes into CRC-16 frames.
// Ports: clk, reset_n, rx_in | rx_data_out, rx_data_valid, frame_done,
//        crc_valid_out, frame_err, busy.
module uart_crc_frame_rx #(
  parameter int          CLKS_PER_BIT  = 16,
  parameter int          PAYLOAD_BYTES = 4,
  parameter int          TIMEOUT_BITS  = 20,
  parameter logic [15:0] CRC_POLY      = 16'h1021,
  parameter logic [15:0] CRC_INIT      = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic [7:0] rx_data_out,
  output logic       rx_data_valid,
  output logic       frame_done,
  output logic       crc_valid_out,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_CYC + 1);
  localparam int BW     = $clog2(PAYLOAD_BYTES + 2);

  localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL    = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);
  localparam logic [BW-1:0] P_IDX   = BW'(PAYLOAD_BYTES);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          s1;
  logic          s2;
  logic          rxs_d;
  logic          rxs;
  logic          fall;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  logic [BW-1:0] bcnt;
  logic [15:0]   crc;
  logic [7:0]    rcv_hi;
  logic [TW-1:0] tcnt;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i])
        r = {r[14:0], 1'b0} ^ CRC_POLY;
      else
        r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign rxs  = s2;
  assign fall = rxs_d & ~rxs;
  assign busy = (state != IDLE) || (bcnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      s1    <= rx_in;
      s2    <= s1;
      rxs_d <= s2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bitn          <= '0;
      sh            <= '0;
      bcnt          <= '0;
      crc           <= CRC_INIT;
      rcv_hi        <= '0;
      tcnt          <= '0;
      rx_data_out   <= '0;
      rx_data_valid <= 1'b0;
      frame_done    <= 1'b0;
      crc_valid_out <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_data_valid <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          // a start edge beats a timeout expiring in the same cycle
          if (fall) begin
            state <= START;
            tcnt  <= '0;
          end else if (bcnt != '0) begin
            if (tcnt == TO_LAST) begin
              frame_err <= 1'b1;
              bcnt      <= '0;
              crc       <= CRC_INIT;
              tcnt      <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end else begin
            tcnt <= '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            bitn  <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt  <= '0;
            sh   <= {rxs, sh[7:1]};
            bitn <= bitn + 1'b1;
            if (bitn == 3'd7)
              state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rxs) begin
              frame_err <= 1'b1;
              bcnt      <= '0;
              crc       <= CRC_INIT;
            end else begin
              unique case (1'b1)
                (bcnt < P_IDX): begin
                  rx_data_out   <= sh;
                  rx_data_valid <= 1'b1;
                  crc           <= crc_step(crc, sh);
                  bcnt          <= bcnt + 1'b1;
                end
                (bcnt == P_IDX): begin
                  rcv_hi <= sh;
                  bcnt   <= bcnt + 1'b1;
                end
                default: begin
                  crc_valid_out <= ({rcv_hi, sh} == crc);
                  frame_done    <= 1'b1;
                  bcnt          <= '0;
                  crc           <= CRC_INIT;
                end
              endcase
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_crc_frame_rx.sv
// Self-checking bench for uart_crc_frame_rx.
// Byte/verdict scoreboard plus per-scenario checks.
module tb_uart_crc_frame_rx;

  localparam int CPB = 16;
  localparam int PB  = 9;
  localparam int TOB = 20;

  typedef logic [7:0] pay_t [PB];

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data_out;
  logic       rx_data_valid;
  logic       frame_done;
  logic       crc_valid_out;
  logic       frame_err;
  logic       busy;

  uart_crc_frame_rx #(
    .CLKS_PER_BIT (CPB),
    .PAYLOAD_BYTES(PB),
    .TIMEOUT_BITS (TOB),
    .CRC_POLY     (16'h1021),
    .CRC_INIT     (16'hFFFF)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_in        (rx_in),
    .rx_data_out  (rx_data_out),
    .rx_data_valid(rx_data_valid),
    .frame_done   (frame_done),
    .crc_valid_out(crc_valid_out),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_done = 0;
  int n_err = 0;
  int last_valid_cyc = 0;
  int last_err_cyc = 0;

  logic [7:0] exp_q[$];
  bit         vq[$];
  logic [7:0] e_byte;
  bit         e_ver;
  pay_t       good;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_data_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL byte_unexpected got %h want none", rx_data_out);
      end else begin
        e_byte = exp_q.pop_front();
        if (rx_data_out !== e_byte) begin
          n_bad++;
          $display("FAIL byte got %h want %h", rx_data_out, e_byte);
        end
      end
    end
    if (frame_done) begin
      n_done++;
      n_cmp++;
      if (vq.size() == 0) begin
        n_bad++;
        $display("FAIL done_unexpected got %b want none", crc_valid_out);
      end else begin
        e_ver = vq.pop_front();
        if (crc_valid_out !== e_ver) begin
          n_bad++;
          $display("FAIL crc_verdict got %b want %b", crc_valid_out, e_ver);
        end
      end
    end
    if (frame_err) begin
      n_err++;
      last_err_cyc = cyc;
    end
  end

  function automatic logic [15:0] model_crc(input pay_t p);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < PB; i++) begin
      c = c ^ {p[i], 8'h00};
      for (int k = 0; k < 8; k++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(CPB);
    end
    rx_in = stop;
    tick(CPB);
    rx_in = 1'b1;
  endtask

  task automatic send_pay(input logic [7:0] b);
    exp_q.push_back(b);
    send_byte(b, 1'b1);
  endtask

  task automatic send_frame(input pay_t p, input logic [15:0] c,
                            input bit ev);
    for (int i = 0; i < PB; i++)
      send_pay(p[i]);
    vq.push_back(ev);
    send_byte(c[15:8], 1'b1);
    send_byte(c[7:0], 1'b1);
    tick(4);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    rx_in = 1'b1;
    tick(10);
    n_cmp += 6;
    if (rx_data_out !== 8'h00) begin
      n_bad++; $display("FAIL rst_data got %h want 00", rx_data_out);
    end
    if (rx_data_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid got %b want 0", rx_data_valid);
    end
    if (frame_done !== 1'b0) begin
      n_bad++; $display("FAIL rst_done got %b want 0", frame_done);
    end
    if (crc_valid_out !== 1'b0) begin
      n_bad++; $display("FAIL rst_crc got %b want 0", crc_valid_out);
    end
    if (frame_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_err got %b want 0", frame_err);
    end
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy got %b want 0", busy);
    end
    reset_n = 1'b1;
    tick(5);
    n_cmp++;
    if ({rx_data_out, rx_data_valid, frame_done, crc_valid_out,
         frame_err, busy} !== 13'h0) begin
      n_bad++;
      $display("FAIL post_rst got %h%b%b%b%b%b want all 0", rx_data_out,
               rx_data_valid, frame_done, crc_valid_out, frame_err, busy);
    end
  endtask

  task automatic test_good_frame;
    int v0, d0, e0;
    v0 = n_valid; d0 = n_done; e0 = n_err;
    send_frame(good, 16'h29B1, 1'b1);
    n_cmp += 5;
    if (n_valid - v0 !== 9) begin
      n_bad++; $display("FAIL good_nvalid got %0d want 9", n_valid - v0);
    end
    if (n_done - d0 !== 1) begin
      n_bad++; $display("FAIL good_ndone got %0d want 1", n_done - d0);
    end
    if (n_err !== e0) begin
      n_bad++; $display("FAIL good_nerr got %0d want 0", n_err - e0);
    end
    if (crc_valid_out !== 1'b1) begin
      n_bad++; $display("FAIL good_crc got %b want 1", crc_valid_out);
    end
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL good_busy got %b want 0", busy);
    end
  endtask

  task automatic test_bad_crc;
    int d0;
    d0 = n_done;
    send_frame(good, 16'h29B0, 1'b0);
    n_cmp += 3;
    if (n_done - d0 !== 1) begin
      n_bad++; $display("FAIL bad_ndone got %0d want 1", n_done - d0);
    end
    if (crc_valid_out !== 1'b0) begin
      n_bad++; $display("FAIL bad_crc got %b want 0", crc_valid_out);
    end
    send_frame(good, 16'h29B1, 1'b1);
    if (crc_valid_out !== 1'b1) begin
      n_bad++; $display("FAIL bad_recover got %b want 1", crc_valid_out);
    end
  endtask

  task automatic test_stop_err;
    int v0, e0, d0;
    v0 = n_valid; e0 = n_err; d0 = n_done;
    send_pay(8'h31);
    send_pay(8'h32);
    send_byte(8'h33, 1'b0);
    tick(2);
    n_cmp += 5;
    if (n_err - e0 !== 1) begin
      n_bad++; $display("FAIL stop_nerr got %0d want 1", n_err - e0);
    end
    if (n_valid - v0 !== 2) begin
      n_bad++; $display("FAIL stop_nvalid got %0d want 2", n_valid - v0);
    end
    if (n_done !== d0) begin
      n_bad++; $display("FAIL stop_ndone got %0d want 0", n_done - d0);
    end
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL stop_busy got %b want 0", busy);
    end
    send_frame(good, 16'h29B1, 1'b1);
    if (crc_valid_out !== 1'b1) begin
      n_bad++; $display("FAIL stop_recover got %b want 1", crc_valid_out);
    end
  endtask

  task automatic test_glitch_timeout;
    int v0, e0, d0;
    v0 = n_valid; e0 = n_err; d0 = n_done;
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    tick(30);
    n_cmp += 2;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL glitch_busy got %b want 0", busy);
    end
    if ((n_valid != v0) || (n_err != e0) || (n_done != d0)) begin
      n_bad++;
      $display("FAIL glitch_activity got v%0d e%0d d%0d want 0 0 0",
               n_valid - v0, n_err - e0, n_done - d0);
    end
    send_pay(8'h31);
    send_pay(8'h32);
    send_pay(8'h33);
    for (int k = 0; k < 500 && n_err == e0; k++)
      tick(1);
    n_cmp += 2;
    if (n_err == e0) begin
      n_bad++; $display("FAIL timeout_none got 0 errors want 1");
    end else if (last_err_cyc - last_valid_cyc !== 320) begin
      n_bad++;
      $display("FAIL timeout_delay got %0d want 320",
               last_err_cyc - last_valid_cyc);
    end
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL timeout_busy got %b want 0", busy);
    end
    send_frame(good, 16'h29B1, 1'b1);
    n_cmp++;
    if (crc_valid_out !== 1'b1) begin
      n_bad++; $display("FAIL timeout_recover got %b want 1", crc_valid_out);
    end
  endtask

  task automatic test_back_to_back;
    pay_t p;
    logic [15:0] c;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < PB; i++)
        p[i] = 8'($urandom_range(0, 255));
      c = model_crc(p);
      send_frame(p, c, 1'b1);
      n_cmp++;
      if (crc_valid_out !== 1'b1) begin
        n_bad++; $display("FAIL b2b_crc%0d got %b want 1", f, crc_valid_out);
      end
    end
    p = good;
    p[3] = 8'h00;
    send_frame(p, 16'h29B1, model_crc(p) == 16'h29B1);
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    send_frame(good, 16'h29B1, 1'b1);
    for (int i = 0; i < 5; i++)
      send_pay(good[i]);
    b = good[5];
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_in = b[i];
      tick(CPB);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rx_data_out, rx_data_valid, frame_done, crc_valid_out,
         frame_err, busy} !== 13'h0) begin
      n_bad++;
      $display("FAIL midrst got %h%b%b%b%b%b want all 0", rx_data_out,
               rx_data_valid, frame_done, crc_valid_out, frame_err, busy);
    end
    tick(3);
    rx_in = 1'b1;
    reset_n = 1'b1;
    tick(4);
    send_frame(good, 16'h29B1, 1'b1);
    n_cmp++;
    if (crc_valid_out !== 1'b1) begin
      n_bad++; $display("FAIL midrst_recover got %b want 1", crc_valid_out);
    end
  endtask

  initial begin
    for (int i = 0; i < PB; i++)
      good[i] = 8'h31 + 8'(i);
    test_reset;
    test_good_frame;
    test_bad_crc;
    test_stop_err;
    test_glitch_timeout;
    test_back_to_back;
    test_reset_mid;
    tick(10);
    n_cmp += 2;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL bytes_left got %0d want 0", exp_q.size());
    end
    if (vq.size() != 0) begin
      n_bad++; $display("FAIL frames_left got %0d want 0", vq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
